// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, fetch FSM state encoding and ISA opcodes for the
//            8-bit processor front end and control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int PC_WIDTH    = 8;
  localparam int INSTR_WIDTH = 16;
  localparam int IMM_WIDTH   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Opcode field values, shared with the control unit's decoder
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b0010;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Combinational next-PC selection: absolute jump beats relative
//            branch beats sequential, all arithmetic modulo 2^PC_WIDTH.
// Revision : 1.0
// ============================================================================
`default_nettype none

module next_pc_calc #(
  parameter int PC_WIDTH  = cpu_pkg::PC_WIDTH,
  parameter int IMM_WIDTH = cpu_pkg::IMM_WIDTH
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 beq,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  addr,
  output logic [PC_WIDTH-1:0]  next_pc
);

  logic [PC_WIDTH-1:0] w_sext_imm;
  logic [PC_WIDTH-1:0] w_seq_pc;
  logic [PC_WIDTH-1:0] w_branch_pc;

  // Branch offset is relative to the word after the branch
  assign w_sext_imm  = {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign w_seq_pc    = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign w_branch_pc = w_seq_pc + w_sext_imm;

  always_comb begin
    next_pc = w_seq_pc;
    if (jump) begin
      next_pc = addr;
    end else if (beq) begin
      next_pc = w_branch_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Owns the PC, fetches words over imem req/ack and hands them to
//            the control unit over valid/ready, applying branch/jump on accept.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int                PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int                INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_ack,
  input  logic [INSTR_WIDTH-1:0]        imem_rdata,
  output logic [INSTR_WIDTH-1:0]        instruction,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          beq,
  input  logic [cpu_pkg::IMM_WIDTH-1:0] imm,
  input  logic                          jump,
  input  logic [PC_WIDTH-1:0]           addr,
  output logic [PC_WIDTH-1:0]           pc
);

  import cpu_pkg::fetch_state_t;
  import cpu_pkg::IDLE;
  import cpu_pkg::REQ;
  import cpu_pkg::HOLD;

  fetch_state_t            r_state;
  fetch_state_t            w_next_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [PC_WIDTH-1:0]     w_next_pc;
  logic [INSTR_WIDTH-1:0]  r_instruction;
  logic                    w_capture;
  logic                    w_accept;

  // Handshakes only count in the state that owns them; stray ack/ready are inert
  assign w_capture = (r_state == REQ)  && imem_ack;
  assign w_accept  = (r_state == HOLD) && instr_ready;

  next_pc_calc #(
    .PC_WIDTH  (PC_WIDTH),
    .IMM_WIDTH (cpu_pkg::IMM_WIDTH)
  ) u_next_pc_calc (
    .pc      (r_pc),
    .beq     (beq),
    .imm     (imm),
    .jump    (jump),
    .addr    (addr),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = REQ;
      REQ:     if (imem_ack)    w_next_state = HOLD;
      HOLD:    if (instr_ready) w_next_state = REQ;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      REQ:     imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // PC advances only on accept, so the next request always targets the new PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instruction <= '0;
    end else begin
      if (w_accept) begin
        r_pc <= w_next_pc;
      end
      if (w_capture) begin
        r_instruction <= imem_rdata;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instruction;

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the 8-bit processor: owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents each word to the control unit with a valid/ready handshake. It also consumes the control unit's branch/jump decisions to compute the next PC. It is the producer side of the instruction/branch interface that the control unit consumes.

## Interface
- PC_WIDTH, 8, program counter and instruction-memory address width (word addressed)
- INSTR_WIDTH, 16, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  PC_WIDTH  fetch address, equal to current PC
- imem_ack  input  1  memory has valid data on imem_rdata this cycle
- imem_rdata  input  INSTR_WIDTH  fetched word
- instruction  output  INSTR_WIDTH  word presented to the control unit
- instr_valid  output  1  instruction holds an unconsumed word
- instr_ready  input  1  control unit accepts the word this cycle
- beq  input  1  take relative branch for the word being accepted
- imm  input  6  signed branch offset in words
- jump  input  1  take absolute jump for the word being accepted
- addr  input  PC_WIDTH  absolute jump target
- pc  output  PC_WIDTH  PC of the word in instruction (debug/trace)

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE: entered on reset; next edge → REQ.
- REQ: imem_req=1, imem_addr=pc, both held stable until imem_ack. On edge with imem_ack=1: capture imem_rdata into instruction, → HOLD.
- HOLD: instr_valid=1, instruction stable. On edge with instr_ready=1 ("accept"): update pc to next PC, → REQ.
- Next PC at accept: jump=1 → addr; else beq=1 → pc + 1 + sext(imm); else pc + 1.
- jump has priority over beq when both are high.
- All PC arithmetic is modulo 2^PC_WIDTH: 8'hFF + 1 = 8'h00; sext(imm) is the 6-bit two's complement offset (range −32..+31) sign-extended to PC_WIDTH.
- beq, imm, jump and addr are sampled only on an accept edge and are ignored otherwise.
- imem_ack outside REQ is ignored; no capture, no state change.
- instr_ready outside HOLD is ignored.
- Reset mid-operation: all state cleared immediately, regardless of FSM state. An imem_ack arriving in the cycle after reset release is ignored because the FSM is in IDLE.

## Timing
- Reset values:
  - pc=RESET_PC, state=IDLE
  - imem_req=0, imem_addr=RESET_PC
  - instruction=16'h0000, instr_valid=0
- First imem_req: asserted 1 cycle after reset deassertion (IDLE → REQ).
- Fetch latency: instr_valid rises on the edge that samples imem_ack; it is visible the cycle after ack.
- With imem_ack high in the first REQ cycle and instr_ready tied high, throughput is 1 instruction per 2 cycles.
- After an accept, imem_req and the new imem_addr are both valid in the next cycle. No request is ever issued to a stale PC.
- Memory wait states: imem_req stays high for any number of cycles until ack.
- Decoder stall: instr_valid stays high and instruction stays stable for any number of cycles until ready.
- pc changes only on accept edges or reset.

## Structure
- Shared package cpu_pkg holds:
  - PC_WIDTH, INSTR_WIDTH and IMM_WIDTH=6 constants
  - the fetch FSM state enum (IDLE/REQ/HOLD)
  - opcode constants for the ISA (add group 4'b0000, addi 4'b0100, lw 4'b1011, sw 4'b1111, beq 4'b1000, j 4'b0010), shared with the control unit
- One combinational sub-module, next_pc_calc: inputs pc, beq, imm, jump, addr; output next_pc. It implements the priority and wrap rules above.
- The FSM, the PC register and the instruction register stay in the top module.

## Test plan
- Reset/first fetch: hold rst high, release. Then imem_req=1 with imem_addr=8'h00 on the next cycle; all outputs are at reset values while rst is high.
- Sequential fetch with wait states: ack after 3 cycles with rdata=16'h4A05, ready high. Then instruction=16'h4A05 and pc=8'h00 are presented, and the next request goes to 8'h01.
- Branch: accept at pc=8'h10 with beq=1, imm=6'b111100 (−4). Next imem_addr=8'h0D. Repeat with imm=6'b011111 at pc=8'hF0: next address 8'h10 (wrap).
- Jump priority and decoder stall:
  - hold ready low for 5 cycles: instr_valid stays 1, instruction is unchanged, and no imem_req is issued
  - then accept with jump=1, addr=8'h42, beq=1: next imem_addr=8'h42
- Spurious handshake and reset: an ack while in HOLD does not change instruction. Asserting rst during REQ drops imem_req in the same cycle; an ack arriving one cycle after release is ignored; the fetch restarts at 8'h00.
